// File: rtl/sd_readout_ctrl_if.sv
// Handshake bundle between the readout sequencer and the SD command/data engines.
// The sequencer is the master: it requests commands and gates block reception.
interface sd_readout_ctrl_if;
   logic        sdcmd_trigger;
   logic [5:0]  sdcmd_idx;
   logic [31:0] sdcmd_arg;
   logic        sdcmd_done;
   logic        sdcmd_err;
   logic        sddat_en;
   logic        sddat_block_done;
   logic        sddat_crc_err;

   modport master (
      output sdcmd_trigger, sdcmd_idx, sdcmd_arg, sddat_en,
      input  sdcmd_done, sdcmd_err, sddat_block_done, sddat_crc_err
   );

   modport slave (
      input  sdcmd_trigger, sdcmd_idx, sdcmd_arg, sddat_en,
      output sdcmd_done, sdcmd_err, sddat_block_done, sddat_crc_err
   );
endinterface

// File: rtl/sd_readout_ctrl.sv
// Multi-block SD readout sequencer: CMD18, per-block data gating against FIFO space,
// CMD12 on completion/abort/CRC error, and a chunk-level SPI data-ready flag.
module sd_readout_ctrl #(
   parameter int FifoBytes  = 4096,
   parameter int BlockBytes = 512,
   parameter int ChunkBytes = 512
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_start,
   input  logic [31:0]                  i_block_addr,
   input  logic [15:0]                  i_block_count,
   input  logic                         i_abort,
   sd_readout_ctrl_if.master            sd,
   input  logic [$clog2(FifoBytes):0]   i_fifo_count,
   output logic                         o_spi_ready,
   output logic                         o_busy,
   output logic                         o_done,
   output logic                         o_err
);

   localparam int              CW          = $clog2(FifoBytes) + 1;
   localparam logic [CW-1:0]   SPACE_LIMIT = CW'(FifoBytes - BlockBytes);
   localparam logic [CW-1:0]   CHUNK_LEVEL = CW'(ChunkBytes);
   localparam logic [5:0]      CMD_RD_MULT = 6'd18;
   localparam logic [5:0]      CMD_STOP    = 6'd12;

   typedef enum logic [2:0] {
      S_IDLE          = 3'd0,
      S_CMD_READ      = 3'd1,
      S_CMD_READ_WAIT = 3'd2,
      S_WAIT_SPACE    = 3'd3,
      S_BLOCK         = 3'd4,
      S_CMD_STOP      = 3'd5,
      S_CMD_STOP_WAIT = 3'd6,
      S_FINISH        = 3'd7
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;

   logic          w_start_acc;
   logic          w_space_ok;
   logic          w_count_hit;
   logic          w_blk_end;
   logic          w_cmd_end;
   logic          w_err_set;
   logic          w_abort_take;

   logic [15:0]   r_block_count;
   logic [15:0]   r_blocks_done;
   logic          r_abort_pend;
   logic          r_tail_pend;
   logic          r_err;
   logic          r_trigger;
   logic [5:0]    r_idx;
   logic [31:0]   r_arg;
   logic          r_dat_en;
   logic          r_busy;
   logic          r_done;
   logic          r_spi_ready;

   assign w_start_acc  = (r_state == S_IDLE) && i_start;
   // Free space = FifoBytes - fifo_count >= BlockBytes, rearranged to avoid underflow.
   assign w_space_ok   = (i_fifo_count <= SPACE_LIMIT);
   assign w_count_hit  = (r_block_count != 16'd0) && (r_blocks_done == r_block_count);
   assign w_blk_end    = (r_state == S_BLOCK) && sd.sddat_block_done;
   assign w_cmd_end    = ((r_state == S_CMD_READ_WAIT) || (r_state == S_CMD_STOP_WAIT))
                         && sd.sdcmd_done;
   assign w_err_set    = (w_cmd_end && sd.sdcmd_err) || (w_blk_end && sd.sddat_crc_err);
   assign w_abort_take = i_abort && (r_state != S_IDLE) && (r_state != S_FINISH);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_start) w_state_nxt = S_CMD_READ;
            else         w_state_nxt = S_IDLE;
         end
         S_CMD_READ:      w_state_nxt = S_CMD_READ_WAIT;
         S_CMD_READ_WAIT: begin
            if (sd.sdcmd_done) begin
               if (sd.sdcmd_err) w_state_nxt = S_FINISH;
               else              w_state_nxt = S_WAIT_SPACE;
            end else begin
               w_state_nxt = S_CMD_READ_WAIT;
            end
         end
         S_WAIT_SPACE: begin
            if (r_abort_pend)     w_state_nxt = S_CMD_STOP;
            else if (w_count_hit) w_state_nxt = S_CMD_STOP;
            else if (w_space_ok)  w_state_nxt = S_BLOCK;
            else                  w_state_nxt = S_WAIT_SPACE;
         end
         S_BLOCK: begin
            if (sd.sddat_block_done) begin
               if (sd.sddat_crc_err) w_state_nxt = S_CMD_STOP;
               else                  w_state_nxt = S_WAIT_SPACE;
            end else begin
               w_state_nxt = S_BLOCK;
            end
         end
         S_CMD_STOP:      w_state_nxt = S_CMD_STOP_WAIT;
         S_CMD_STOP_WAIT: begin
            if (sd.sdcmd_done) w_state_nxt = S_FINISH;
            else               w_state_nxt = S_CMD_STOP_WAIT;
         end
         S_FINISH:        w_state_nxt = S_IDLE;
         default:         w_state_nxt = S_IDLE;
      endcase
   end

   // Sequence bookkeeping and registered outputs, all decoded from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_block_count <= 16'd0;
         r_blocks_done <= 16'd0;
         r_abort_pend  <= 1'b0;
         r_tail_pend   <= 1'b0;
         r_err         <= 1'b0;
         r_trigger     <= 1'b0;
         r_idx         <= 6'd0;
         r_arg         <= 32'd0;
         r_dat_en      <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_spi_ready   <= 1'b0;
      end else begin
         if (w_start_acc) begin
            r_block_count <= i_block_count;
            r_blocks_done <= 16'd0;
            r_abort_pend  <= 1'b0;
            r_tail_pend   <= 1'b0;
            r_err         <= 1'b0;
         end else begin
            r_block_count <= r_block_count;
            r_blocks_done <= w_blk_end ? (r_blocks_done + 16'd1) : r_blocks_done;
            r_abort_pend  <= r_abort_pend | w_abort_take;
            r_tail_pend   <= r_tail_pend | (r_state == S_FINISH);
            r_err         <= r_err | w_err_set;
         end

         // idx/arg hold their value until the next command request
         r_trigger <= (w_state_nxt == S_CMD_READ) || (w_state_nxt == S_CMD_STOP);
         if (w_state_nxt == S_CMD_READ) begin
            r_idx <= CMD_RD_MULT;
            r_arg <= i_block_addr;
         end else if (w_state_nxt == S_CMD_STOP) begin
            r_idx <= CMD_STOP;
            r_arg <= 32'd0;
         end else begin
            r_idx <= r_idx;
            r_arg <= r_arg;
         end

         r_dat_en    <= (w_state_nxt == S_BLOCK);
         r_busy      <= (w_state_nxt != S_IDLE);
         r_done      <= (w_state_nxt == S_FINISH);
         r_spi_ready <= (i_fifo_count >= CHUNK_LEVEL)
                        || (r_tail_pend && (i_fifo_count != {CW{1'b0}}));
      end
   end

   assign sd.sdcmd_trigger = r_trigger;
   assign sd.sdcmd_idx     = r_idx;
   assign sd.sdcmd_arg     = r_arg;
   assign sd.sddat_en      = r_dat_en;
   assign o_spi_ready      = r_spi_ready;
   assign o_busy           = r_busy;
   assign o_done           = r_done;
   assign o_err            = r_err;

endmodule
